// File: rtl/bpm_pulse_estimator.sv
// rtl/bpm_pulse_estimator.sv - beat detector with interval-to-BPM divider; optional BPM_SMOOTH_EN smoothing
module bpm_pulse_estimator #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_BITS = 16,
  parameter int BITS        = 8,
  parameter int MIN_BPM     = 40,
  parameter int MAX_BPM     = 200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [SAMPLE_BITS-1:0] sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          filter_enable,
  input  logic [SAMPLE_BITS-2:0]        threshold,
  output logic [$clog2(MAX_BPM+1)-1:0]  BPM_estimate,
  output logic [BITS-1:0]               pulse_amplitude,
  output logic                          bpm_valid,
  output logic                          beat
);

  localparam int BPM_W = $clog2(MAX_BPM + 1);
  localparam int MAG_W = SAMPLE_BITS - 1;

  // 60*CLK_HZ exceeds 32-bit signed range at 50 MHz, so derive limits in 64 bits
  localparam logic [63:0] DIVIDEND_64 = 64'd60 * 64'(CLK_HZ);
  localparam logic [63:0] MAX_INT_64  = DIVIDEND_64 / 64'(MIN_BPM);
  localparam logic [63:0] MIN_INT_64  = DIVIDEND_64 / 64'(MAX_BPM);
  localparam int          CNT_NAT     = $clog2(MAX_INT_64 + 64'd1);
  localparam int          CNT_W       = (CNT_NAT > 27) ? CNT_NAT : 27;

  localparam logic [CNT_W-1:0] MAX_INTERVAL = MAX_INT_64[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MIN_INTERVAL = MIN_INT_64[CNT_W-1:0];
  localparam logic [31:0]      DIVIDEND     = DIVIDEND_64[31:0];
  localparam logic [BPM_W-1:0] MAX_BPM_V    = BPM_W'(MAX_BPM);

  // iterations 0..31 divide, 32 clamps, 33 publishes -> bpm_valid 34 cycles after beat
  localparam logic [5:0] DIV_ITERS = 6'd32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] peak_q, peak_d;
  logic [BITS-1:0]  amp_q, amp_d;
  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic             beat_q, beat_d;
  logic             bpmv_q, bpmv_d;
  logic             ready_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [5:0]       div_cnt_q, div_cnt_d;
  logic [BPM_W-1:0] res_q, res_d;

  logic             accept;
  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] pk;
  logic             qualified;
  logic [CNT_W:0]   trial;
  logic [BPM_W-1:0] bpm_new;

  assign accept = sample_valid && ready_q;

  // absolute value; the most negative sample saturates to the largest magnitude
  always_comb begin
    mag = sample_in[MAG_W-1:0];
    if (sample_in[SAMPLE_BITS-1]) begin
      if (sample_in[MAG_W-1:0] == '0) begin
        mag = '1;
      end else begin
        mag = ~sample_in[MAG_W-1:0] + MAG_W'(1);
      end
    end
  end

  assign pk = (mag > peak_q) ? mag : peak_q;

  // a beat needs a strong enough sample and, once armed, the refractory time elapsed
  assign qualified = accept && (mag >= threshold) && filter_enable &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_ARMED) && (cnt_q >= MIN_INTERVAL)));

  assign trial = {rem_q, quo_q[31]};

`ifdef BPM_SMOOTH_EN
  logic             have_bpm_q, have_bpm_d;
  logic [BPM_W+1:0] sm_sum;

  assign sm_sum  = ({2'b00, bpm_q} << 1) + {2'b00, bpm_q} + {2'b00, res_q};
  assign bpm_new = have_bpm_q ? BPM_W'(sm_sum >> 2) : res_q;

  // forget the running average whenever the tracker has dropped back to idle
  always_comb begin
    have_bpm_d = have_bpm_q;
    if (state_q == S_IDLE) begin
      have_bpm_d = 1'b0;
    end else if (bpmv_d) begin
      have_bpm_d = 1'b1;
    end
  end

  // smoothing history register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      have_bpm_q <= 1'b0;
    end else begin
      have_bpm_q <= have_bpm_d;
    end
  end
`else
  assign bpm_new = res_q;
`endif

  // next-state: beat detection, interval counting and the sequential divider
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == MAX_INTERVAL) ? MAX_INTERVAL : cnt_q + CNT_W'(1);
    peak_d    = accept ? pk : peak_q;
    amp_d     = amp_q;
    bpm_d     = bpm_q;
    beat_d    = 1'b0;
    bpmv_d    = 1'b0;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    div_cnt_d = div_cnt_q;
    res_d     = res_q;

    if (qualified) begin
      beat_d = 1'b1;
      amp_d  = pk[MAG_W-1 -: BITS];
      peak_d = '0;
      cnt_d  = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (qualified) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (qualified) begin
          state_d   = S_DIVIDE;
          dvs_d     = cnt_q;
          rem_d     = '0;
          quo_d     = DIVIDEND;
          div_cnt_d = '0;
        end else if (cnt_q == MAX_INTERVAL) begin
          state_d = S_IDLE;
        end
      end
      S_DIVIDE: begin
        if (div_cnt_q < DIV_ITERS) begin
          if (trial >= {1'b0, dvs_q}) begin
            rem_d = CNT_W'(trial - {1'b0, dvs_q});
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = trial[CNT_W-1:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          div_cnt_d = div_cnt_q + 6'd1;
        end else if (div_cnt_q == DIV_ITERS) begin
          res_d     = (quo_q > 32'(MAX_BPM)) ? MAX_BPM_V : quo_q[BPM_W-1:0];
          div_cnt_d = div_cnt_q + 6'd1;
        end else begin
          bpm_d   = bpm_new;
          bpmv_d  = 1'b1;
          state_d = S_ARMED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // disabling the filter parks the tracker and abandons any divide in flight
    if (!filter_enable) begin
      state_d = S_IDLE;
      bpmv_d  = 1'b0;
      bpm_d   = bpm_q;
    end
  end

  // state registers, all cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      peak_q    <= '0;
      amp_q     <= '0;
      bpm_q     <= '0;
      beat_q    <= 1'b0;
      bpmv_q    <= 1'b0;
      ready_q   <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      div_cnt_q <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      peak_q    <= peak_d;
      amp_q     <= amp_d;
      bpm_q     <= bpm_d;
      beat_q    <= beat_d;
      bpmv_q    <= bpmv_d;
      ready_q   <= 1'b1;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      div_cnt_q <= div_cnt_d;
      res_q     <= res_d;
    end
  end

  assign sample_ready    = ready_q;
  assign BPM_estimate    = bpm_q;
  assign pulse_amplitude = amp_q;
  assign bpm_valid       = bpmv_q;
  assign beat            = beat_q;

endmodule

// File: tb/tb_bpm_pulse_estimator.sv
// tb/tb_bpm_pulse_estimator.sv - directed self-checking bench for bpm_pulse_estimator
module tb_bpm_pulse_estimator;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        filter_enable;
  logic [14:0] threshold;
  logic [7:0]  BPM_estimate;
  logic [7:0]  pulse_amplitude;
  logic        bpm_valid;
  logic        beat;

  int          n_cmp;
  int          n_bad;
  logic [7:0]  exp_hold;

  bpm_pulse_estimator #(
    .CLK_HZ      (1000),
    .SAMPLE_BITS (16),
    .BITS        (8),
    .MIN_BPM     (40),
    .MAX_BPM     (200)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .filter_enable   (filter_enable),
    .threshold       (threshold),
    .BPM_estimate    (BPM_estimate),
    .pulse_amplitude (pulse_amplitude),
    .bpm_valid       (bpm_valid),
    .beat            (beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one sample for one cycle, then zeros for the rest of gap cycles
  task automatic send_spike(input logic [15:0] val, input int gap, input bit exp_beat,
                            input logic [7:0] exp_amp, input bit exp_bpm,
                            input logic [7:0] exp_val, input string name);
    int         beat_k;
    int         bpm_k;
    int         n_beat;
    int         n_bpm;
    logic [7:0] amp_seen;
    logic [7:0] bpm_seen;
    beat_k = 0; bpm_k = 0; n_beat = 0; n_bpm = 0;
    amp_seen = '0; bpm_seen = '0;
    sample_in = val;
    for (int k = 1; k <= gap; k++) begin
      @(posedge clk); #1;
      sample_in = '0;
      if (beat === 1'b1) begin
        n_beat++;
        if (beat_k == 0) begin beat_k = k; amp_seen = pulse_amplitude; end
      end
      if (bpm_valid === 1'b1) begin
        n_bpm++;
        if (bpm_k == 0) begin bpm_k = k; bpm_seen = BPM_estimate; end
      end
    end
    if (exp_bpm) exp_hold = exp_val;
    n_cmp++;
    if (beat_k !== (exp_beat ? 1 : 0) || n_beat !== (exp_beat ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s beat: first at cycle %0d count %0d, required cycle %0d count %0d",
               name, beat_k, n_beat, exp_beat ? 1 : 0, exp_beat ? 1 : 0);
    end
    if (exp_beat) begin
      n_cmp++;
      if (amp_seen !== exp_amp) begin
        n_bad++;
        $display("FAIL %s amplitude: got %h, required %h", name, amp_seen, exp_amp);
      end
    end
    n_cmp++;
    if (bpm_k !== (exp_bpm ? 35 : 0) || n_bpm !== (exp_bpm ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s bpm_valid: first at cycle %0d count %0d, required cycle %0d count %0d",
               name, bpm_k, n_bpm, exp_bpm ? 35 : 0, exp_bpm ? 1 : 0);
    end
    if (exp_bpm) begin
      n_cmp++;
      if (bpm_seen !== exp_val) begin
        n_bad++;
        $display("FAIL %s bpm value: got %0d, required %0d", name, bpm_seen, exp_val);
      end
    end
    n_cmp++;
    if (BPM_estimate !== exp_hold) begin
      n_bad++;
      $display("FAIL %s bpm held: got %0d, required %0d", name, BPM_estimate, exp_hold);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_valid = 1'b1; filter_enable = 1'b1;
    threshold = 15'h1000; sample_in = 16'h4000;
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if ({BPM_estimate, pulse_amplitude, bpm_valid, beat, sample_ready} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset outputs: bpm %0d amp %h valid %b beat %b ready %b, required all 0",
               BPM_estimate, pulse_amplitude, bpm_valid, beat, sample_ready);
    end
    sample_in = '0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (sample_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset ready_before_edge: got %b, required 0", sample_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sample_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset ready_after_edge: got %b, required 1", sample_ready);
    end
    exp_hold = 8'd0;
  endtask

  task automatic test_periodic();
    send_spike(16'h4000, 500, 1, 8'h80, 0, 8'd0,   "periodic_first");
    send_spike(16'h4000, 500, 1, 8'h80, 1, 8'd120, "periodic_2");
    send_spike(16'h4000, 500, 1, 8'h80, 1, 8'd120, "periodic_3");
    send_spike(16'h4000, 500, 1, 8'h80, 1, 8'd120, "periodic_4");
  endtask

  task automatic test_refractory();
    send_spike(16'h4000, 100, 1, 8'h80, 1, 8'd120, "refr_beat");
    send_spike(16'h4000, 400, 0, 8'h00, 0, 8'd0,   "refr_extra");
    send_spike(16'h4000, 500, 1, 8'h80, 1, 8'd120, "refr_after");
  endtask

  task automatic test_timeout();
    send_spike(16'h4000, 1600, 1, 8'h80, 1, 8'd120, "timeout_gap");
    send_spike(16'h4000, 400,  1, 8'h80, 0, 8'd0,   "timeout_rearm");
    send_spike(16'h4000, 400,  1, 8'h80, 1, 8'd150, "timeout_150");
    send_spike(16'h4000, 400,  1, 8'h80, 1, 8'd150, "timeout_150b");
  endtask

  task automatic test_magnitude();
    send_spike(16'h8001, 400, 1, 8'hFF, 1, 8'd150, "mag_neg7fff");
    send_spike(16'h8000, 400, 1, 8'hFF, 1, 8'd150, "mag_neg8000");
    send_spike(16'h0FFF, 400, 0, 8'h00, 0, 8'd0,   "mag_below");
    send_spike(16'h4000, 300, 1, 8'h80, 1, 8'd75,  "mag_after_below");
  endtask

  task automatic test_boundary();
    send_spike(16'h4000, 1,    0, 8'h00, 0, 8'd0,   "bound_cnt299");
    send_spike(16'h4000, 1501, 1, 8'h80, 1, 8'd200, "bound_cnt300");
    send_spike(16'h4000, 500,  1, 8'h80, 1, 8'd40,  "bound_cnt1500");
    send_spike(16'h1000, 500,  1, 8'h20, 1, 8'd120, "bound_thresh_pos");
    send_spike(16'hF000, 500,  1, 8'h20, 1, 8'd120, "bound_thresh_neg");
  endtask

  task automatic test_filter_enable();
    int n_beat;
    int n_bpm;
    int beat_k;
    n_beat = 0; n_bpm = 0; beat_k = 0;
    sample_in = 16'h4000;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      sample_in = '0;
      if (beat === 1'b1) begin n_beat++; if (beat_k == 0) beat_k = k; end
      if (bpm_valid === 1'b1) n_bpm++;
      if (k == 10) filter_enable = 1'b0;
      if (k == 15) sample_in = 16'h4000;
      if (k == 20) filter_enable = 1'b1;
    end
    n_cmp++;
    if (beat_k !== 1 || n_beat !== 1) begin
      n_bad++;
      $display("FAIL fen beats: first %0d count %0d, required first 1 count 1", beat_k, n_beat);
    end
    n_cmp++;
    if (n_bpm !== 0) begin
      n_bad++;
      $display("FAIL fen abort: bpm_valid count %0d, required 0", n_bpm);
    end
    n_cmp++;
    if (BPM_estimate !== 8'd120 || pulse_amplitude !== 8'h80) begin
      n_bad++;
      $display("FAIL fen hold: bpm %0d amp %h, required 120 80", BPM_estimate, pulse_amplitude);
    end
    send_spike(16'h4000, 400, 1, 8'h80, 0, 8'd0,   "fen_rearm");
    send_spike(16'h4000, 400, 1, 8'h80, 1, 8'd150, "fen_resume");
  endtask

  task automatic test_reset_mid_divide();
    int n_beat;
    int n_bpm;
    n_beat = 0; n_bpm = 0;
    sample_in = 16'h4000;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      sample_in = '0;
      if (k == 1) begin
        n_cmp++;
        if (beat !== 1'b1) begin
          n_bad++;
          $display("FAIL rstdiv beat: got %b, required 1", beat);
        end
      end
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({BPM_estimate, pulse_amplitude, bpm_valid, beat, sample_ready} !== 19'd0) begin
      n_bad++;
      $display("FAIL rstdiv async: bpm %0d amp %h valid %b beat %b ready %b, required all 0",
               BPM_estimate, pulse_amplitude, bpm_valid, beat, sample_ready);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    exp_hold = 8'd0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_cmp++;
        if (sample_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL rstdiv ready: got %b, required 1", sample_ready);
        end
      end
      if (beat === 1'b1) n_beat++;
      if (bpm_valid === 1'b1) n_bpm++;
    end
    n_cmp++;
    if (n_bpm !== 0 || n_beat !== 0) begin
      n_bad++;
      $display("FAIL rstdiv after_release: bpm_valid %0d beat %0d, required 0 0", n_bpm, n_beat);
    end
    send_spike(16'h4000, 500, 1, 8'h80, 0, 8'd0,   "rstdiv_first");
    send_spike(16'h4000, 500, 1, 8'h80, 1, 8'd120, "rstdiv_second");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_hold = 8'd0;
    test_reset();
    test_periodic();
    test_refractory();
    test_timeout();
    test_magnitude();
    test_boundary();
    test_filter_enable();
    test_reset_mid_divide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
